// File: rtl/banco_reg_param_if.sv
// Register-bank port bundle: write port, two read ports, clear control and debug read.
// The master side drives addresses and data; the slave side is the register bank.
interface banco_reg_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
    logic              wr_drop;
    logic [ADDR_W-1:0] dbg_idx;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output we3, wa3, wd3, ra1, ra2, clr_req, dbg_idx,
        input  rd1, rd2, busy, clr_done, wr_drop, dbg_data
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, clr_req, dbg_idx,
        output rd1, rd2, busy, clr_done, wr_drop, dbg_data
    );
endinterface

// File: rtl/banco_reg_param.sv
// Parameterised register bank with optional zero register, write-to-read forwarding
// and a one-entry-per-cycle clear sweep (IDLE -> CLEAR -> DONE).
module banco_reg_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    banco_reg_param_if.slave  bus
);
    localparam int unsigned       DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic clearing;
    logic wr_en;
    logic fwd1, fwd2;

    assign clearing = (state_q == StClear);
    // Writes are refused during the sweep and, with a zero register, at address 0.
    assign wr_en    = bus.we3 && !clearing && !(ZERO_REG && (bus.wa3 == '0));
    assign fwd1     = BYPASS && wr_en && (bus.wa3 == bus.ra1);
    assign fwd2     = BYPASS && wr_en && (bus.wa3 == bus.ra2);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (ptr_q == LastIdx) begin
                    state_d = StDone;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= bus.we3 && clearing;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[bus.wa3] <= bus.wd3;
            end
            if (clearing) begin
                mem_q[ptr_q] <= '0;
            end
        end
    end

    assign bus.rd1 = fwd1 ? bus.wd3 :
                     (ZERO_REG && (bus.ra1 == '0)) ? '0 : mem_q[bus.ra1];
    assign bus.rd2 = fwd2 ? bus.wd3 :
                     (ZERO_REG && (bus.ra2 == '0)) ? '0 : mem_q[bus.ra2];

    assign bus.dbg_data = mem_q[bus.dbg_idx];
    assign bus.busy     = clearing;
    assign bus.clr_done = (state_q == StDone);
    assign bus.wr_drop  = wr_drop_q;
endmodule

// File: doc/banco_reg_param.md
BANCO_REG_PARAM -- requirements
Module: banco_reg_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL provide parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; port names are clk and rst, in that order, ahead of all other ports.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 we3  input  1  write enable.
REQ-009 wa3  input  ADDR_W  write address.
REQ-010 wd3  input  DATA_W  write data.
REQ-011 ra1, ra2  input  ADDR_W  read addresses.
REQ-012 rd1, rd2  output  DATA_W  combinational read data.
REQ-013 clr_req  input  1  request a sequential clear of all registers.
REQ-014 busy  output  1  clear sweep in progress.
REQ-015 clr_done  output  1  one-cycle pulse at sweep completion.
REQ-016 wr_drop  output  1  one-cycle pulse flagging a write discarded during the sweep.
REQ-017 dbg_idx  input  ADDR_W, dbg_data  output  DATA_W  combinational debug read of array entry dbg_idx, no bypass.

Function
REQ-018 Write: on a rising clk edge in state IDLE or DONE, we3=1 SHALL store wd3 at wa3; the array value is visible on rd1/rd2/dbg_data after that edge.
REQ-019 ZERO_REG=1: writes to address 0 SHALL be discarded, with no wr_drop; reads of address 0 SHALL return 0.
REQ-020 BYPASS=1, state not CLEAR, we3=1, wa3==ra1, and the write is not discarded SHALL give rd1=wd3 in the same cycle; rd2 SHALL behave the same way against ra2.
REQ-021 Otherwise rd1/rd2 SHALL return the array contents at ra1/ra2; with BYPASS=0 there is no forwarding.
REQ-022 FSM states SHALL be IDLE, CLEAR and DONE.
REQ-023 IDLE: clr_req=1 SHALL move to CLEAR with pointer ptr=0; a write in the same cycle SHALL be performed.
REQ-024 CLEAR: each cycle SHALL zero entry ptr and then increment ptr.
REQ-025 CLEAR: at ptr==DEPTH-1, the last entry SHALL be zeroed and the FSM SHALL move to DONE; the sweep lasts exactly DEPTH cycles.
REQ-026 DONE SHALL last one cycle, drive clr_done=1, and then move to IDLE.
REQ-027 DONE SHALL accept writes and SHALL ignore clr_req.
REQ-028 busy SHALL be 1 only in CLEAR; busy and clr_done SHALL both be registered state decodes.
REQ-029 CLEAR: we3=1 SHALL not modify the array, and wr_drop SHALL be 1 in the following cycle.
REQ-030 CLEAR: clr_req SHALL be ignored and SHALL not restart the sweep.
REQ-031 CLEAR: reads SHALL return the current array contents, so entries at or above ptr hold their old values.
REQ-032 ptr SHALL be ADDR_W bits wide and SHALL not wrap past DEPTH-1 within a sweep.

Reset
REQ-033 rst=0 SHALL immediately, independent of clk, zero all array entries, set the FSM to IDLE, and set ptr=0, busy=0, clr_done=0 and wr_drop=0.
REQ-034 Reset asserted in the middle of a sweep SHALL abort the sweep with no clr_done pulse.
REQ-035 The first edge after rst deasserts SHALL operate normally from IDLE.

Verification
REQ-036 Write/read: write 0xA5 to reg 3, then ra1=3 -> rd1=0xA5 on the next cycle; reg0 write of 0xFF -> rd2=0x00 with ra2=0.
REQ-037 Bypass: reg5=0x11, then same-cycle we3=1, wa3=5, wd3=0x22, ra1=5 -> rd1=0x22 before the edge and dbg_data(idx5)=0x11 before the edge; BYPASS=0 build -> rd1=0x11.
REQ-038 Clear sweep: fill regs 1-7 with 0x10-0x16, pulse clr_req -> busy=1 for exactly 8 cycles, then clr_done=1 for 1 cycle, then all entries read 0x00.
REQ-039 Write during sweep: we3=1, wa3=6, wd3=0x77 in the 3rd CLEAR cycle -> wr_drop=1 the next cycle and reg6=0x00 after the sweep; a second clr_req mid-sweep does not extend busy.
REQ-040 Simultaneous: in IDLE, clr_req=1 together with a write of 0x99 to reg 7 -> the write takes effect, then the sweep clears reg 7 to 0x00.
REQ-041 Async reset mid-sweep: assert rst=0 between clk edges at ptr=4 -> busy=0 immediately, no clr_done, all entries 0x00; the next write after release succeeds.
